// File: rtl/regbank_pkg.sv
// Shared definitions for the register bank access sequencer:
// default widths and the sequencer state encoding.
package regbank_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int ADDR_WIDTH_DEF = 4;

   localparam logic [2:0] ENC_IDLE  = 3'd0;
   localparam logic [2:0] ENC_WRITE = 3'd1;
   localparam logic [2:0] ENC_READ1 = 3'd2;
   localparam logic [2:0] ENC_READ2 = 3'd3;
   localparam logic [2:0] ENC_RESP  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = ENC_IDLE,
      ST_WRITE = ENC_WRITE,
      ST_READ1 = ENC_READ1,
      ST_READ2 = ENC_READ2,
      ST_RESP  = ENC_RESP
   } seq_state_t;

endpackage

// File: rtl/regbank_access_sequencer_if.sv
// Bundle of the fetch/response/write-back handshakes and the
// single-port register bank signals driven by the sequencer.
interface regbank_access_sequencer_if
   import regbank_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_rs1;
   logic [ADDR_WIDTH-1:0] req_rs2;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rs1_data;
   logic [DATA_WIDTH-1:0] rsp_rs2_data;

   logic                  wb_valid;
   logic                  wb_ready;
   logic [ADDR_WIDTH-1:0] wb_rd;
   logic [DATA_WIDTH-1:0] wb_data;

   logic [ADDR_WIDTH-1:0] bank_reg_num;
   logic [DATA_WIDTH-1:0] bank_wdata;
   logic                  bank_we;
   logic [DATA_WIDTH-1:0] bank_rdata;

   modport slave (
      input  req_valid, req_rs1, req_rs2,
      output req_ready,
      output rsp_valid, rsp_rs1_data, rsp_rs2_data,
      input  rsp_ready,
      input  wb_valid, wb_rd, wb_data,
      output wb_ready,
      output bank_reg_num, bank_wdata, bank_we,
      input  bank_rdata
   );

   modport master (
      output req_valid, req_rs1, req_rs2,
      input  req_ready,
      input  rsp_valid, rsp_rs1_data, rsp_rs2_data,
      output rsp_ready,
      output wb_valid, wb_rd, wb_data,
      input  wb_ready,
      input  bank_reg_num, bank_wdata, bank_we,
      output bank_rdata
   );

endinterface

// File: rtl/regbank_access_sequencer.sv
// Serialises two-operand fetches and write-backs onto the
// single port of the register bank; write-back wins ties.
module regbank_access_sequencer
   import regbank_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter bit ZERO_REG   = 1'b1
) (
   input  logic                         clk,
   input  logic                         reset,
   regbank_access_sequencer_if.slave    bus
);

   seq_state_t            state, state_n;
   logic [ADDR_WIDTH-1:0] rs2_q, rs2_n;
   logic [ADDR_WIDTH-1:0] reg_num, reg_num_n;
   logic [DATA_WIDTH-1:0] wdata, wdata_n;
   logic                  we, we_n;
   logic                  rsp_valid, rsp_valid_n;
   logic [DATA_WIDTH-1:0] rs1_data, rs1_data_n;
   logic [DATA_WIDTH-1:0] rs2_data, rs2_data_n;
   logic [DATA_WIDTH-1:0] rd_val;
   logic                  rd_is_zero;

   // Index 0 may be hardwired to zero; applies to the index on the port now.
   always_comb begin
      rd_is_zero = ZERO_REG && (reg_num == '0);
      rd_val     = rd_is_zero ? '0 : bus.bank_rdata;
   end

   // Next-state and next-register values for the sequencer.
   always_comb begin
      state_n     = state;
      rs2_n       = rs2_q;
      reg_num_n   = reg_num;
      wdata_n     = wdata;
      we_n        = 1'b0;
      rsp_valid_n = rsp_valid;
      rs1_data_n  = rs1_data;
      rs2_data_n  = rs2_data;
      unique case (state)
         ST_IDLE: begin
            if (bus.wb_valid) begin
               reg_num_n = bus.wb_rd;
               wdata_n   = bus.wb_data;
               we_n      = !(ZERO_REG && (bus.wb_rd == '0));
               state_n   = ST_WRITE;
            end else if (bus.req_valid) begin
               rs2_n     = bus.req_rs2;
               reg_num_n = bus.req_rs1;
               state_n   = ST_READ1;
            end
         end
         ST_WRITE: begin
            state_n = ST_IDLE;
         end
         ST_READ1: begin
            rs1_data_n = rd_val;
            reg_num_n  = rs2_q;
            state_n    = ST_READ2;
         end
         ST_READ2: begin
            rs2_data_n  = rd_val;
            rsp_valid_n = 1'b1;
            state_n     = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_n = 1'b0;
               state_n     = ST_IDLE;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // State and registered bank/response outputs; reset aborts any op.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         rs2_q     <= '0;
         reg_num   <= '0;
         wdata     <= '0;
         we        <= 1'b0;
         rsp_valid <= 1'b0;
         rs1_data  <= '0;
         rs2_data  <= '0;
      end else begin
         state     <= state_n;
         rs2_q     <= rs2_n;
         reg_num   <= reg_num_n;
         wdata     <= wdata_n;
         we        <= we_n;
         rsp_valid <= rsp_valid_n;
         rs1_data  <= rs1_data_n;
         rs2_data  <= rs2_data_n;
      end
   end

   // Upstream readiness: write-back only needs IDLE; fetch yields to it.
   always_comb begin
      bus.wb_ready  = (state == ST_IDLE);
      bus.req_ready = (state == ST_IDLE) && !bus.wb_valid;
   end

   // Registered outputs onto the bundle.
   always_comb begin
      bus.bank_reg_num = reg_num;
      bus.bank_wdata   = wdata;
      bus.bank_we      = we;
      bus.rsp_valid    = rsp_valid;
      bus.rsp_rs1_data = rs1_data;
      bus.rsp_rs2_data = rs2_data;
   end

endmodule
